// File: rtl/core_bus_sched.sv
// Shares one external memory bus between instruction fetch and load/store, with data priority,
// a bounded-burst fetch starvation guard, a transaction timeout and halt drain.
module core_bus_sched #(
    parameter int MAX_DATA_BURST = 4,
    parameter int TIMEOUT        = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        insn_req,
    input  logic [29:0] insn_addr,
    output logic        insn_ready,
    output logic [31:0] insn_data_rd,
    input  logic        data_req,
    input  logic        data_write,
    input  logic [29:0] data_addr,
    input  logic [31:0] data_data_wr,
    input  logic [3:0]  data_data_be,
    output logic        data_ready,
    output logic [31:0] data_data_rd,
    output logic        bus_err,
    input  logic        halt,
    output logic        halted,
    output logic [29:0] bus_addr,
    output logic        bus_start,
    output logic        bus_write,
    output logic [31:0] bus_data_wr,
    output logic [3:0]  bus_data_be,
    input  logic        bus_ready,
    input  logic [31:0] bus_data_rd,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {IDLE = 2'd0, INSN = 2'd1, DATA = 2'd2} state_t;

    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
    localparam logic [3:0] BURST_MAX = 4'(MAX_DATA_BURST);

    state_t        state;
    logic [3:0]    burst;
    logic [TW-1:0] tcnt;
    logic          grant_data;
    logic          grant_insn;
    logic          timed_out;

    assign dbg_state = state;

    // Handshake: a requester raises *_req with stable address/data and holds it until it sees
    // the one-cycle *_ready pulse; it drops req in that same cycle, so a held req is never
    // served twice. On the bus side bus_start marks the first cycle and bus_ready ends it.
    always_comb begin
        grant_data = 1'b0;
        grant_insn = 1'b0;
        if (state == IDLE && !halt) begin
            grant_data = data_req && !(insn_req && burst == BURST_MAX);
            grant_insn = !grant_data && insn_req;
        end
    end

    // bus_ready in the last counted cycle wins over the timeout.
    assign timed_out = (TIMEOUT != 0) && !bus_ready && (tcnt == TIMEOUT_LAST);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            burst        <= 4'd0;
            tcnt         <= '0;
            insn_ready   <= 1'b0;
            insn_data_rd <= 32'h0;
            data_ready   <= 1'b0;
            data_data_rd <= 32'h0;
            bus_err      <= 1'b0;
            halted       <= 1'b0;
            bus_addr     <= 30'h0;
            bus_start    <= 1'b0;
            bus_write    <= 1'b0;
            bus_data_wr  <= 32'h0;
            bus_data_be  <= 4'b0000;
        end else begin
            insn_ready <= 1'b0;
            data_ready <= 1'b0;
            bus_err    <= 1'b0;
            bus_start  <= 1'b0;
            halted     <= halt && (state == IDLE);
            case (state)
                IDLE: begin
                    if (grant_insn || !insn_req) begin
                        burst <= 4'd0;
                    end else if (grant_data && burst != BURST_MAX) begin
                        burst <= burst + 4'd1;
                    end
                    if (grant_data) begin
                        state       <= DATA;
                        bus_addr    <= data_addr;
                        bus_write   <= data_write;
                        bus_data_wr <= data_data_wr;
                        bus_data_be <= data_data_be;
                        bus_start   <= 1'b1;
                        tcnt        <= '0;
                    end else if (grant_insn) begin
                        state       <= INSN;
                        bus_addr    <= insn_addr;
                        bus_write   <= 1'b0;
                        bus_data_wr <= 32'h0;
                        bus_data_be <= 4'b1111;
                        bus_start   <= 1'b1;
                        tcnt        <= '0;
                    end
                end
                default: begin
                    if (bus_ready || timed_out) begin
                        state       <= IDLE;
                        bus_addr    <= 30'h0;
                        bus_write   <= 1'b0;
                        bus_data_wr <= 32'h0;
                        bus_data_be <= 4'b0000;
                        bus_err     <= !bus_ready;
                        if (state == INSN) begin
                            insn_ready   <= 1'b1;
                            insn_data_rd <= bus_ready ? bus_data_rd : 32'h0;
                        end else begin
                            data_ready   <= 1'b1;
                            data_data_rd <= bus_ready ? bus_data_rd : 32'h0;
                        end
                    end else begin
                        tcnt <= tcnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_core_bus_sched.sv
// Testbench for core_bus_sched: bus responder model, per-port scoreboards and scenario tasks.
module tb_core_bus_sched;

    logic        clk;
    logic        rst;
    logic        insn_req;
    logic [29:0] insn_addr;
    logic        insn_ready;
    logic [31:0] insn_data_rd;
    logic        data_req;
    logic        data_write;
    logic [29:0] data_addr;
    logic [31:0] data_data_wr;
    logic [3:0]  data_data_be;
    logic        data_ready;
    logic [31:0] data_data_rd;
    logic        bus_err;
    logic        halt;
    logic        halted;
    logic [29:0] bus_addr;
    logic        bus_start;
    logic        bus_write;
    logic [31:0] bus_data_wr;
    logic [3:0]  bus_data_be;
    logic        bus_ready;
    logic [31:0] bus_data_rd;
    logic [1:0]  dbg_state;

    int n_run;
    int n_fail;
    int resp_delay;

    // {write, be, addr, wdata} in expected bus order; {err, rdata} per port
    logic [66:0] exp_bus_q[$];
    logic [32:0] exp_insn_q[$];
    logic [32:0] exp_data_q[$];

    core_bus_sched #(.MAX_DATA_BURST(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .insn_req(insn_req), .insn_addr(insn_addr), .insn_ready(insn_ready), .insn_data_rd(insn_data_rd),
        .data_req(data_req), .data_write(data_write), .data_addr(data_addr),
        .data_data_wr(data_data_wr), .data_data_be(data_data_be),
        .data_ready(data_ready), .data_data_rd(data_data_rd),
        .bus_err(bus_err), .halt(halt), .halted(halted),
        .bus_addr(bus_addr), .bus_start(bus_start), .bus_write(bus_write),
        .bus_data_wr(bus_data_wr), .bus_data_be(bus_data_be),
        .bus_ready(bus_ready), .bus_data_rd(bus_data_rd), .dbg_state(dbg_state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] mem_rd(input logic [29:0] a);
        if (a == 30'h100) return 32'hE3A00001;
        return {a[15:0], ~a[15:0]};
    endfunction

    task automatic exp_bus(input logic w, input logic [3:0] be, input logic [29:0] a,
                           input logic [31:0] wd);
        exp_bus_q.push_back({w, be, a, w ? wd : 32'h0});
    endtask

    task automatic responder();
        logic [29:0] a;
        forever begin
            @(negedge clk);
            if (bus_start && resp_delay >= 0) begin
                a = bus_addr;
                repeat (resp_delay) @(negedge clk);
                bus_data_rd = mem_rd(a);
                bus_ready   = 1'b1;
                @(negedge clk);
                bus_ready   = 1'b0;
                bus_data_rd = 32'h0;
            end
        end
    endtask

    task automatic mon_bus();
        logic [66:0] e;
        logic [66:0] got;
        forever begin
            @(negedge clk);
            if (bus_start) begin
                n_run++;
                if (exp_bus_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL bus_start_unexpected: got addr=%h write=%b", bus_addr, bus_write);
                end else begin
                    e   = exp_bus_q.pop_front();
                    got = {bus_write, bus_data_be, bus_addr, e[66] ? bus_data_wr : 32'h0};
                    if (got !== e) begin
                        n_fail++;
                        $display("FAIL bus_txn: got %h expected %h", got, e);
                    end
                end
            end
        end
    endtask

    task automatic mon_ready();
        logic [32:0] e;
        forever begin
            @(negedge clk);
            if (insn_ready) begin
                n_run++;
                if (exp_insn_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL insn_ready_unexpected: got data=%h", insn_data_rd);
                end else begin
                    e = exp_insn_q.pop_front();
                    if ({bus_err, insn_data_rd} !== e) begin
                        n_fail++;
                        $display("FAIL insn_resp: got %h expected %h", {bus_err, insn_data_rd}, e);
                    end
                end
            end
            if (data_ready) begin
                n_run++;
                if (exp_data_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL data_ready_unexpected: got data=%h", data_data_rd);
                end else begin
                    e = exp_data_q.pop_front();
                    if ({bus_err, data_data_rd} !== e) begin
                        n_fail++;
                        $display("FAIL data_resp: got %h expected %h", {bus_err, data_data_rd}, e);
                    end
                end
            end
        end
    endtask

    task automatic insn_drive(input logic [29:0] a);
        int n;
        n = 0;
        exp_insn_q.push_back({1'b0, mem_rd(a)});
        insn_addr = a;
        insn_req  = 1'b1;
        do begin @(negedge clk); n++; end while (!insn_ready && n < 100);
        insn_req = 1'b0;
        n_run++;
        if (!insn_ready) begin
            n_fail++;
            $display("FAIL insn_wait: got no insn_ready after %0d cycles, expected a pulse", n);
        end
    endtask

    task automatic data_drive(input logic w, input logic [29:0] a, input logic [31:0] wd,
                              input logic [3:0] be);
        int n;
        n = 0;
        exp_data_q.push_back({1'b0, mem_rd(a)});
        data_write   = w;
        data_addr    = a;
        data_data_wr = wd;
        data_data_be = be;
        data_req     = 1'b1;
        do begin @(negedge clk); n++; end while (!data_ready && n < 100);
        data_req = 1'b0;
        n_run++;
        if (!data_ready) begin
            n_fail++;
            $display("FAIL data_wait: got no data_ready after %0d cycles, expected a pulse", n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_run++;
        if ({insn_ready, insn_data_rd, data_ready, data_data_rd, bus_err, halted, bus_addr,
             bus_start, bus_write, bus_data_wr, bus_data_be, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got addr=%h be=%h start=%b halted=%b state=%0d, expected all 0",
                     bus_addr, bus_data_be, bus_start, halted, dbg_state);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        int c;
        resp_delay = 2;
        exp_bus(1'b0, 4'hF, 30'h100, 32'h0);
        exp_insn_q.push_back({1'b0, 32'hE3A00001});
        insn_addr = 30'h100;
        insn_req  = 1'b1;
        @(negedge clk);
        n_run++;
        if (bus_start !== 1'b1) begin
            n_fail++;
            $display("FAIL fetch_latency: got bus_start=%b one cycle after req, expected 1", bus_start);
        end
        c = 0;
        do begin @(negedge clk); c++; end while (!insn_ready && c < 50);
        insn_req = 1'b0;
        n_run++;
        if (c != 3) begin
            n_fail++;
            $display("FAIL fetch_ready_delay: got %0d cycles after bus_start, expected 3", c);
        end
        n_run++;
        if ({bus_addr, bus_write, bus_data_be, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL fetch_bus_release: got addr=%h be=%h state=%0d, expected 0",
                     bus_addr, bus_data_be, dbg_state);
        end
        @(negedge clk);
    endtask

    task automatic test_simultaneous();
        resp_delay = 1;
        exp_bus(1'b1, 4'h3, 30'h40, 32'hDEADBEEF);
        exp_bus(1'b0, 4'hF, 30'h200, 32'h0);
        fork
            data_drive(1'b1, 30'h40, 32'hDEADBEEF, 4'h3);
            insn_drive(30'h200);
        join
        @(negedge clk);
    endtask

    task automatic test_random();
        logic [29:0] a;
        logic [31:0] wd;
        logic [3:0]  be;
        int          kind;
        for (int i = 0; i < 12; i++) begin
            resp_delay = $urandom_range(0, 3);
            kind = $urandom_range(0, 2);
            a    = 30'($urandom_range(0, 32'h3FFF));
            wd   = $urandom;
            be   = 4'($urandom_range(1, 15));
            if (kind == 0) begin
                exp_bus(1'b0, 4'hF, a, 32'h0);
                insn_drive(a);
            end else begin
                exp_bus(kind == 2, be, a, wd);
                data_drive(kind == 2, a, wd, be);
            end
        end
        @(negedge clk);
    endtask

    task automatic test_starvation();
        int n;
        resp_delay = 1;
        for (int k = 0; k < 4; k++) exp_bus(1'b0, 4'h5, 30'h500 + 30'(k), 32'h0);
        exp_bus(1'b0, 4'hF, 30'h600, 32'h0);
        for (int k = 4; k < 6; k++) exp_bus(1'b0, 4'h5, 30'h500 + 30'(k), 32'h0);
        fork
            insn_drive(30'h600);
            begin
                data_write   = 1'b0;
                data_data_be = 4'h5;
                data_data_wr = 32'h0;
                data_req     = 1'b1;
                for (int k = 0; k < 6; k++) begin
                    data_addr = 30'h500 + 30'(k);
                    exp_data_q.push_back({1'b0, mem_rd(data_addr)});
                    n = 0;
                    do begin @(negedge clk); n++; end while (!data_ready && n < 100);
                    n_run++;
                    if (!data_ready) begin
                        n_fail++;
                        $display("FAIL starve_wait: got no data_ready for burst item %0d", k);
                    end
                end
                data_req = 1'b0;
            end
        join
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int s;
        int r;
        int c;
        resp_delay = -1;
        exp_bus(1'b0, 4'hC, 30'h77, 32'h0);
        exp_data_q.push_back({1'b1, 32'h0});
        data_write   = 1'b0;
        data_addr    = 30'h77;
        data_data_be = 4'hC;
        data_data_wr = 32'h1234;
        data_req     = 1'b1;
        s = -1;
        r = -1;
        c = 0;
        while (r < 0 && c < 60) begin
            @(negedge clk);
            if (bus_start) s = c;
            if (data_ready) r = c;
            c++;
        end
        data_req = 1'b0;
        n_run++;
        if (s < 0 || r < 0 || r - s != 8) begin
            n_fail++;
            $display("FAIL timeout_delay: got start=%0d ready=%0d, expected ready 8 cycles after start", s, r);
        end
        resp_delay = 1;
        exp_bus(1'b0, 4'hF, 30'h78, 32'h0);
        data_drive(1'b0, 30'h78, 32'h0, 4'hF);
        @(negedge clk);
    endtask

    task automatic test_halt_drain();
        int  n;
        logic bad;
        resp_delay = 4;
        exp_bus(1'b1, 4'hF, 30'h300, 32'hCAFEF00D);
        exp_data_q.push_back({1'b0, mem_rd(30'h300)});
        data_write   = 1'b1;
        data_addr    = 30'h300;
        data_data_wr = 32'hCAFEF00D;
        data_data_be = 4'hF;
        data_req     = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_start && n < 20);
        halt      = 1'b1;
        insn_addr = 30'h104;
        insn_req  = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!data_ready && n < 50);
        data_req = 1'b0;
        n_run++;
        if (data_ready !== 1'b1 || halted !== 1'b0) begin
            n_fail++;
            $display("FAIL halt_drain: got data_ready=%b halted=%b, expected 1 and 0", data_ready, halted);
        end
        @(negedge clk);
        n_run++;
        if (halted !== 1'b1) begin
            n_fail++;
            $display("FAIL halted_rise: got %b one cycle after IDLE, expected 1", halted);
        end
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (bus_start !== 1'b0 || halted !== 1'b1) bad = 1'b1;
        end
        n_run++;
        if (bad) begin
            n_fail++;
            $display("FAIL halt_block: got bus_start or halted drop while halted, expected none");
        end
        exp_bus(1'b0, 4'hF, 30'h104, 32'h0);
        halt = 1'b0;
        @(negedge clk);
        n_run++;
        if (halted !== 1'b0 || bus_start !== 1'b1) begin
            n_fail++;
            $display("FAIL halt_release: got halted=%b bus_start=%b, expected 0 and 1", halted, bus_start);
        end
        insn_drive(30'h104);
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int  n;
        logic bad;
        resp_delay = 3;
        exp_bus(1'b0, 4'h9, 30'h123, 32'h0);
        data_write   = 1'b0;
        data_addr    = 30'h123;
        data_data_be = 4'h9;
        data_req     = 1'b1;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus_start && n < 20);
        rst      = 1'b1;
        data_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        n_run++;
        if ({data_ready, bus_addr, bus_start, bus_write, bus_data_wr, bus_data_be, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid: got addr=%h be=%h start=%b state=%0d, expected all 0",
                     bus_addr, bus_data_be, bus_start, dbg_state);
        end
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (data_ready !== 1'b0 || bus_start !== 1'b0 || dbg_state !== 2'd0) bad = 1'b1;
        end
        n_run++;
        if (bad) begin
            n_fail++;
            $display("FAIL late_ready: got a ready pulse or start after reset, expected IDLE and quiet");
        end
    endtask

    initial begin
        n_run        = 0;
        n_fail       = 0;
        resp_delay   = 1;
        rst          = 1'b1;
        insn_req     = 1'b0;
        insn_addr    = 30'h0;
        data_req     = 1'b0;
        data_write   = 1'b0;
        data_addr    = 30'h0;
        data_data_wr = 32'h0;
        data_data_be = 4'h0;
        halt         = 1'b0;
        bus_ready    = 1'b0;
        bus_data_rd  = 32'h0;
        fork
            responder();
            mon_bus();
            mon_ready();
        join_none
        test_reset();
        test_single_fetch();
        test_simultaneous();
        test_random();
        test_starvation();
        test_timeout();
        test_halt_drain();
        test_reset_mid();
        n_run++;
        if (exp_bus_q.size() != 0 || exp_insn_q.size() != 0 || exp_data_q.size() != 0) begin
            n_fail++;
            $display("FAIL leftover: got bus=%0d insn=%0d data=%0d pending, expected 0",
                     exp_bus_q.size(), exp_insn_q.size(), exp_data_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule

// File: doc/core_bus_sched.md
Name: core_bus_sched

Overview:
- Shares the single external memory bus between the instruction-fetch port (read-only) and the load/store data port (read/write, byte enables).
- Sits between the core's fetch/ldst units and the bus, and drives all bus control signals from registers.
- Data port has priority; a bounded-burst fairness counter prevents fetch starvation.
- Supports a halt request that drains the in-flight transaction and then parks the bus.

Parameters:
- MAX_DATA_BURST, 4: consecutive data grants allowed while fetch is pending before fetch is forced next; range 1..15.
- TIMEOUT, 255: cycles to wait for bus_ready before aborting the transaction; 0 disables the timeout.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- insn_req  in  1  fetch request; level, held until insn_ready
- insn_addr  in  30  fetch word address; stable while insn_req
- insn_ready  out  1  one-cycle pulse: fetch done, insn_data_rd valid this cycle
- insn_data_rd  out  32  read data for fetch
- data_req  in  1  data request; level, held until data_ready
- data_write  in  1  1 = write; stable while data_req
- data_addr  in  30  data word address
- data_data_wr  in  32  write data
- data_data_be  in  4  byte enables
- data_ready  out  1  one-cycle pulse: data transaction done
- data_data_rd  out  32  read data for the data port
- bus_err  out  1  pulses together with insn_ready/data_ready when the transaction timed out
- halt  in  1  stop issuing new transactions
- halted  out  1  high while halt=1 and no transaction is outstanding
- bus_addr  out  30  bus word address
- bus_start  out  1  one-cycle transaction start
- bus_write  out  1  write qualifier
- bus_data_wr  out  32  bus write data
- bus_data_be  out  4  bus byte enables
- bus_ready  in  1  bus completion pulse
- bus_data_rd  in  32  bus read data

Behaviour:
- Reset values:
  - All outputs 0, except halted = 0 and bus_data_be = 4'b0000.
  - State IDLE, burst counter 0, timeout counter 0.
  - Reset mid-transaction abandons it; no ready pulse is produced, and a late bus_ready in IDLE is ignored.
- States: IDLE, INSN, DATA.
- IDLE grant, evaluated each cycle (halt=1 blocks all grants):
  - Data is granted if data_req && !(insn_req && burst == MAX_DATA_BURST).
  - Otherwise fetch is granted if insn_req.
- Grant registers the following at the same clock edge, so bus_start is high exactly in the first cycle of INSN/DATA:
  - bus_addr
  - bus_write (0 for fetch)
  - bus_data_wr
  - bus_data_be (4'b1111 for fetch)
  - bus_start = 1
- Latency: request seen in cycle N gives bus_start in cycle N+1.
- bus_addr, bus_write, bus_data_wr and bus_data_be hold until completion, then return to 0.
- Completion in INSN/DATA:
  - A cycle with bus_ready=1 pulses the matching *_ready in the next cycle.
  - bus_data_rd is latched into the matching *_data_rd; the other port's data output holds its old value.
  - State returns to IDLE in that same next cycle.
  - Minimum back-to-back spacing: ready pulse in IDLE, next bus_start one cycle later. The requester drops req on the cycle it sees ready, so a held req is not double-served.
- Burst counter:
  - Increments (saturating at MAX_DATA_BURST) on each data grant while insn_req=1.
  - Clears on any fetch grant, or when insn_req=0 in IDLE.
- Timeout:
  - Counter clears on grant and increments each cycle in INSN/DATA without bus_ready.
  - When it reaches TIMEOUT: pulse *_ready with bus_err=1, *_data_rd = 32'h0, return to IDLE.
  - bus_ready coinciding with the timeout cycle counts as normal completion, with no error.
- Simultaneous insn_req and data_req in IDLE with burst < MAX: data wins.
- halt:
  - Never aborts an in-flight transaction.
  - halted = halt && state==IDLE, registered, so it rises one cycle after entering IDLE under halt.
  - halted drops in the cycle after halt deasserts.
  - Requests held during halt are served after release, with normal priority.
- bus_ready while bus_start=1 in the same cycle is legal (single-cycle memory) and completes the transaction.

Test Plan:
- Single fetch: insn_req, addr 30'h100, bus_ready 2 cycles after bus_start with data 32'hE3A00001 -> one bus_start, bus_write=0, be=4'hF, insn_ready pulse, insn_data_rd=32'hE3A00001.
- Simultaneous requests: insn_req and data write (addr 30'h40, data 32'hDEADBEEF, be 4'h3) raised together -> data served first with bus_write=1, be=4'h3; fetch served next.
- Starvation: data_req held high continuously, insn_req high, MAX_DATA_BURST=4 -> exactly 4 data transactions, then 1 fetch, then data resumes.
- Timeout: TIMEOUT=8, bus_ready never asserted -> ready pulse with bus_err=1 and data 0 exactly 8 cycles after bus_start; next request proceeds normally.
- Halt drain: halt asserted mid-data-transaction -> transaction completes, halted rises one cycle after IDLE, pending insn_req gets no bus_start until halt drops.
- Reset mid-transaction: rst during DATA, then bus_ready after reset -> no data_ready pulse, all bus outputs 0, IDLE.
